// File: rtl/accumulator_file_pkg.sv
// rtl/accumulator_file_pkg.sv - op codes and engine state encoding for accumulator_file
package accumulator_file_pkg;

  typedef enum logic [2:0] {
    OP_NOP = 3'd0,
    OP_INC = 3'd1,
    OP_DEC = 3'd2,
    OP_CLR = 3'd3,
    OP_SHL = 3'd4,
    OP_SHR = 3'd5,
    OP_ROL = 3'd6,
    OP_ROR = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Shifts and rotates occupy the upper half of the op space.
  function automatic logic is_shift(input op_e op);
    return op[2];
  endfunction

endpackage

// File: rtl/accumulator_step_unit.sv
// rtl/accumulator_step_unit.sv - one combinational step of an in-place accumulator op
module accumulator_step_unit
  import accumulator_file_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] value,
  input  op_e              op,
  output logic [WIDTH-1:0] next_value,
  output logic             carry
);

  always_comb begin
    next_value = value;
    carry      = 1'b0;
    case (op)
      OP_INC: {carry, next_value} = {1'b0, value} + {{WIDTH{1'b0}}, 1'b1};
      // Top bit of the widened difference is the borrow out.
      OP_DEC: {carry, next_value} = {1'b0, value} - {{WIDTH{1'b0}}, 1'b1};
      OP_CLR: next_value = '0;
      OP_SHL: begin
        next_value = {value[WIDTH-2:0], 1'b0};
        carry      = value[WIDTH-1];
      end
      OP_SHR: begin
        next_value = {1'b0, value[WIDTH-1:1]};
        carry      = value[0];
      end
      OP_ROL: begin
        next_value = {value[WIDTH-2:0], value[WIDTH-1]};
        carry      = value[WIDTH-1];
      end
      OP_ROR: begin
        next_value = {value[0], value[WIDTH-1:1]};
        carry      = value[0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/accumulator_file.sv
// rtl/accumulator_file.sv - accumulator bank on the W bus with a sequential in-place op engine
// Optional zero/carry status flags are built when ACC_FLAGS_EN is defined.
module accumulator_file
  import accumulator_file_pkg::*;
#(
  parameter  int WIDTH    = 8,
  parameter  int NUM_REGS = 4,
  localparam int SEL_W    = $clog2(NUM_REGS),
  localparam int SH_W     = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             enable,
  input  logic [SEL_W-1:0] sel,
  input  logic [2:0]       op,
  input  logic [SH_W-1:0]  shamt,
  input  logic             op_start,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] alu_connection,
  inout  wire  [WIDTH-1:0] w_bus
`ifdef ACC_FLAGS_EN
  ,
  output logic             zero_flag,
  output logic             carry_flag
`endif
);

  logic [WIDTH-1:0] regs [NUM_REGS];
  state_e           state;
  op_e              op_q;
  logic [SEL_W-1:0] tgt;
  logic [SH_W-1:0]  cnt;
  logic [SH_W-1:0]  start_cnt;
  logic [WIDTH-1:0] step_next;
  logic             step_carry;
  logic             step_en;
  logic             load_ok;

  assign alu_connection = regs[sel];
  assign w_bus          = enable ? regs[sel] : {WIDTH{1'bz}};

  // The running op owns its target until the engine returns to idle.
  assign load_ok = load && !enable && !(busy && (sel == tgt));
  assign step_en = (state == ST_RUN);

  always_comb begin
    start_cnt = SH_W'(1);
    if (is_shift(op_e'(op)))
      start_cnt = shamt;
    else if (op_e'(op) == OP_NOP)
      start_cnt = '0;
  end

  accumulator_step_unit #(.WIDTH(WIDTH)) u_step (
    .value      (regs[tgt]),
    .op         (op_q),
    .next_value (step_next),
    .carry      (step_carry)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      tgt   <= '0;
      op_q  <= OP_NOP;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (op_start) begin
            tgt  <= sel;
            op_q <= op_e'(op);
            cnt  <= start_cnt;
            busy <= 1'b1;
            if (start_cnt == '0) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          cnt <= cnt - SH_W'(1);
          if (cnt == SH_W'(1)) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (step_en && (tgt == SEL_W'(i)))
          regs[i] <= step_next;
        else if (load_ok && (sel == SEL_W'(i)))
          regs[i] <= w_bus;
      end
    end
  end

`ifdef ACC_FLAGS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      zero_flag  <= 1'b0;
      carry_flag <= 1'b0;
    end else if (step_en) begin
      zero_flag  <= (step_next == '0);
      carry_flag <= step_carry;
    end else if (load_ok) begin
      zero_flag  <= (w_bus == '0);
    end
  end
`else
  logic unused_step_carry;
  assign unused_step_carry = step_carry;
`endif

endmodule

// File: doc/accumulator_file.md
# accumulator_file

Parametrised successor to the SAP-1 A register: a bank of `NUM_REGS` accumulators, each `WIDTH` bits wide, sharing the tri-state W bus and the ALU side port. It adds a sequential in-place operation engine for increment, decrement, clear, and multi-cycle shifts and rotates, controlled by a start/busy/done handshake. Status flags are optional. It sits where the single A register sat, between the W bus and the ALU.

## Interface
Parameters:
- `WIDTH`, default 8: register and bus width, at least 2.
- `NUM_REGS`, default 4: number of accumulators, at least 2.
- `SEL_W` (localparam): `$clog2(NUM_REGS)`.
- `SH_W` (localparam): `$clog2(WIDTH)`.

Ports:
- `clk`, input, 1: single clock; all state changes on its rising edge.
- `reset`, input, 1: asynchronous, active-low reset (0 = reset).
- `load`, input, 1: write `w_bus` into `reg[sel]`.
- `enable`, input, 1: drive `reg[sel]` onto `w_bus`; otherwise high-Z.
- `sel`, input, `SEL_W`: register selected for load, enable, ALU port and op target.
- `op`, input, 3: operation code, sampled with `op_start`.
- `shamt`, input, `SH_W`: shift/rotate amount, sampled with `op_start`.
- `op_start`, input, 1: start-operation request.
- `busy`, output, 1: engine not idle.
- `done`, output, 1: one-cycle completion pulse.
- `alu_connection`, output, `WIDTH`: combinational `reg[sel]`.
- `w_bus`, inout, `WIDTH`: shared system bus.
- `zero_flag`, `carry_flag`, output, 1 each: present only with `ACC_FLAGS_EN`.

## Operation
- **Op codes:**
  - 0 NOP
  - 1 INC
  - 2 DEC
  - 3 CLR
  - 4 SHL (logical)
  - 5 SHR (logical)
  - 6 ROL
  - 7 ROR
- **FSM states:** IDLE, RUN, DONE.
- **IDLE:** when `op_start`=1, latch `tgt`←`sel`, `op`, and a step count `cnt`:
  - shift/rotate ops: `cnt`=`shamt`
  - INC/DEC/CLR: `cnt`=1
  - NOP: `cnt`=0
  - Next state is DONE if `cnt`=0, otherwise RUN.
- **RUN:** each cycle applies one step to `reg[tgt]` (±1, clear, or a 1-bit shift/rotate) and decrements `cnt`. When `cnt`=1 at that edge, go to DONE.
- **DONE:** `done`=1 for exactly one cycle, then go to IDLE.
- `busy` = (state ≠ IDLE).
- `op_start` while `busy`=1 is ignored. It is not queued.
- **Arithmetic:** modulo 2^`WIDTH`. INC of all-ones gives 0; DEC of 0 gives all-ones.
- **Load rules:**
  - `load` with `enable`=1: the load is ignored and the bus is driven by the block.
  - `load` while `busy` and `sel`=`tgt`: dropped; the op owns the register.
  - `load` to any other register: always proceeds.
  - `load` in IDLE in the same cycle as `op_start` on the same register: the load lands at that edge, and the op operates on the loaded value.
- `w_bus` is driven only when `enable`=1. Otherwise all bits are Z.
- `alu_connection` tracks `sel` combinationally, including mid-operation.
- **Reset (any time, including mid-op):**
  - all registers 0
  - state IDLE
  - `busy`=0, `done`=0
  - flags 0
  - `w_bus` Z
  - A pending operation is abandoned.

## Timing
- The `op_start` edge is E0.
- INC/DEC/CLR: result visible after E1; `done` high from E1 to E2; `busy` high from E0 to E2.
- Shift/rotate by k≥1: result after edge Ek; `done` high from Ek to Ek+1.
- NOP or shift by 0: `done` from E0 to E1; register unchanged.
- Load latency: one edge. `alu_connection` reflects the new value right after the edge.
- Bus output: combinational from `enable`, `sel` and the register; no registered delay.

## Configuration
- **`ACC_FLAGS_EN` defined:**
  - `zero_flag` and `carry_flag` are registered.
  - `zero_flag` updates on every op step and every accepted load to (new value == 0).
  - `carry_flag` updates on every op step:
    - INC: carry-out.
    - DEC: borrow.
    - SHL/ROL: old MSB.
    - SHR/ROR: old LSB.
    - CLR: 0.
  - Load leaves `carry_flag` unchanged.
- **Undefined:** both flag ports and the flag logic are absent. All other behaviour is identical.

## Structure
- **Package `accumulator_file_pkg`:**
  - op-code constants/enum (`OP_NOP` … `OP_ROR`)
  - FSM state encoding (`ST_IDLE`, `ST_RUN`, `ST_DONE`)
- **Sub-module `accumulator_step_unit`:** combinational single-step datapath.
  - Inputs: value, op.
  - Outputs: next value, carry.
  - Instantiated once and shared by the engine.

## Test plan
- Reset low, then high; `load`=1, `sel`=2, `w_bus`=0x0F; then `enable`=1 → `w_bus`=0x0F and `alu_connection`=0x0F; with `enable`=0, `w_bus` is Z.
- `reg[1]`=0xFF, INC → `busy` for 2 cycles, `done` pulse, `reg[1]`=0x00, `zero_flag`=1, `carry_flag`=1.
- `reg[0]`=0x81, SHL with `shamt`=3 → `done` at E3, `reg[0]`=0x08, `carry_flag`=0; then ROR with `shamt`=4 → 0x80.
- During a 5-cycle shift on `reg[3]`: `load` to `reg[3]` is dropped, `load` to `reg[0]` is applied, and a second `op_start` is ignored.
- Reset asserted at E2 of an SHL by 6 → all registers 0, `busy`=0, `done`=0 immediately (asynchronously), and no `done` pulse after release.
- `load` and `enable` both high with an external driver at Z → register unchanged, and the block drives `w_bus`.
